// File: rtl/lcd_timer_pkg.sv
// Shared types and constants for the LCD programmable delay timer.
package lcd_timer_pkg;

  localparam int unsigned DEF_WIDTH = 26;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Standard LCD waits expressed in 50 MHz clock cycles.
  localparam int unsigned DLY_40US   = 2000;
  localparam int unsigned DLY_1P64MS = 82000;
  localparam int unsigned DLY_15MS   = 750000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lcd_tick_prescaler.sv
// Tick generator: one tick every PRESCALE enabled cycles; holds while disabled.
// Only instantiated when LCD_DELAY_PRESCALE_EN is defined.
module lcd_tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam int unsigned DIV = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_pcnt;
  logic          w_wrap;

  assign w_wrap   = (r_pcnt == PW'(DIV - 1));
  assign o_tick_c = i_enable & w_wrap;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_pcnt <= '0;
    end else if (i_enable) begin
      r_pcnt <= w_wrap ? '0 : r_pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/lcd_delay_timer.sv
// Programmable one-shot/periodic delay timer with pause and abort.
// Optional tick prescaler enabled by defining LCD_DELAY_PRESCALE_EN.
module lcd_delay_timer
  import lcd_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] delay_cycles,
  input  logic             mode,
  input  logic             enable,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] clk_cnt
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_term, w_term_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_done, w_done_nxt;
  logic             w_tick;
  logic             w_expire;

  assign w_expire = (r_cnt == r_term - WIDTH'(1));

`ifdef LCD_DELAY_PRESCALE_EN
  logic w_pclr;

  // Restart the prescaler phase whenever a period begins or is cancelled.
  assign w_pclr = (r_state == IDLE) ? (start & ~abort)
                                    : (abort | (enable & w_tick & w_expire));

  lcd_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .i_clear  (w_pclr),
    .o_tick_c (w_tick)
  );
`else
  // Every cycle is a tick; PRESCALE has no effect in this build.
  assign w_tick = (PRESCALE >= 1) | 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_term  <= '0;
      r_mode  <= MODE_ONESHOT;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_term  <= w_term_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_term_nxt  = r_term;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (start && !abort) begin
          w_term_nxt  = (delay_cycles == '0) ? WIDTH'(1) : delay_cycles;
          w_mode_nxt  = mode;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (enable && w_tick) begin
          if (w_expire) begin
            w_done_nxt = 1'b1;
            w_cnt_nxt  = '0;
            if (r_mode == MODE_ONESHOT) begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign clk_cnt = r_cnt;

endmodule
